// File: rtl/alu_control_md.sv
// alu_control_md
// ALU control decode plus an iterative multiply/divide sequencer that owns
// HI/LO. Decode is purely combinational. The sequencer runs one radix-2 step
// per cycle, then applies sign correction and writes HI/LO.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   aluOp       00 add, 01 sub, 1x R-type (decode funct)
//   funct       R-type function field
//   issue       instruction in EX is valid this cycle
//   opA, opB    rs / rt operand values
//   aluControl  4-bit ALU operation code
//   illegal     unsupported funct with aluOp=1x
//   stall       hold pipeline (HI/LO consumer or MD op while sequencer busy)
//   mdBusy      sequencer not idle
//   mdDone      high in the cycle before HI/LO update
//   hi, lo      HI / LO registers
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an MD op; accepts it without stalling
// BUSY  | one shift-add / restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO write, mdDone asserted
module alu_control_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       aluOp,
    input  logic [5:0]       funct,
    input  logic             issue,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [3:0]       aluControl,
    output logic             illegal,
    output logic             stall,
    output logic             mdBusy,
    output logic             mdDone,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Upper half: running product / partial remainder.
    // Lower half: multiplier / dividend being shifted out, quotient shifted in.
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     opd_q, opd_d;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     orig_a_q, orig_a_d; // raw opA, needed for divide-by-zero
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic                 div_q, div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 is_md;
    logic                 sgn_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   fix_prod;
    logic [WIDTH-1:0]     quo, remd;

    always_comb begin
        aluControl = 4'b1111;
        illegal    = 1'b0;
        if (!aluOp[1]) begin
            aluControl = aluOp[0] ? 4'b0110 : 4'b0010;
        end else begin
            case (funct)
                6'd32, 6'd33: aluControl = 4'b0010;
                6'd34, 6'd35: aluControl = 4'b0110;
                6'd36:        aluControl = 4'b0000;
                6'd37:        aluControl = 4'b0001;
                6'd38:        aluControl = 4'b0011;
                6'd39:        aluControl = 4'b0100;
                6'd42:        aluControl = 4'b0111;
                6'd43:        aluControl = 4'b1000;
                6'd0:         aluControl = 4'b1001;
                6'd2:         aluControl = 4'b1010;
                6'd3:         aluControl = 4'b1011;
                6'd16:        aluControl = 4'b1100;
                6'd18:        aluControl = 4'b1101;
                6'd24, 6'd25, 6'd26, 6'd27: aluControl = 4'b1111;
                default:      illegal = 1'b1;
            endcase
        end
    end

    assign is_md  = aluOp[1] && (funct[5:2] == 4'b0110);
    assign mdBusy = (state_q != ST_IDLE);
    assign mdDone = (state_q == ST_FIX);
    assign stall  = mdBusy && issue && aluOp[1] &&
                    ((funct[5:2] == 4'b0110) || (funct == 6'd16) || (funct == 6'd18));

    // funct[0]=0 selects the signed variant, funct[1]=1 selects divide.
    assign sgn_op = ~funct[0];
    assign a_neg  = sgn_op & opA[WIDTH-1];
    assign b_neg  = sgn_op & opB[WIDTH-1];
    assign mag_a  = a_neg ? -opA : opA;
    assign mag_b  = b_neg ? -opB : opB;

    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                      {1'b0, (prod_q[0] ? opd_q : {WIDTH{1'b0}})};
    // Remainder < divisor, so the shifted value always fits in WIDTH+1 bits.
    assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opd_q};
    assign fix_prod = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
    assign quo      = prod_q[WIDTH-1:0];
    assign remd     = prod_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opd_d    = opd_q;
        orig_a_d = orig_a_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div_d    = div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (issue && is_md) begin
                    state_d  = ST_BUSY;
                    cnt_d    = '0;
                    div_d    = funct[1];
                    neg_a_d  = a_neg;
                    neg_b_d  = b_neg;
                    orig_a_d = opA;
                    prod_d   = {{WIDTH{1'b0}}, (funct[1] ? mag_a : mag_b)};
                    opd_d    = funct[1] ? mag_b : mag_a;
                end
            end
            ST_BUSY: begin
                if (div_q) begin
                    if (!div_diff[WIDTH])
                        prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                    else
                        prod_d = {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
                end else begin
                    prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (div_q) begin
                    if (opd_q == '0) begin
                        lo_d = '1;
                        hi_d = orig_a_q;
                    end else begin
                        // MIN / -1 falls out naturally: magnitude quotient is MIN, no negation.
                        lo_d = (neg_a_q ^ neg_b_q) ? -quo : quo;
                        hi_d = neg_a_q ? -remd : remd;
                    end
                end else begin
                    hi_d = fix_prod[2*WIDTH-1:WIDTH];
                    lo_d = fix_prod[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            opd_q    <= '0;
            orig_a_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opd_q    <= opd_d;
            orig_a_q <= orig_a_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
module tb_alu_control_md;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    aluOp = 2'b00;
    logic [5:0]    funct = 6'd0;
    logic          issue = 1'b0;
    logic [W-1:0]  opA = '0;
    logic [W-1:0]  opB = '0;
    logic [3:0]    aluControl;
    logic          illegal, stall, mdBusy, mdDone;
    logic [W-1:0]  hi, lo;

    alu_control_md #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .aluOp(aluOp), .funct(funct), .issue(issue),
        .opA(opA), .opB(opB), .aluControl(aluControl), .illegal(illegal),
        .stall(stall), .mdBusy(mdBusy), .mdDone(mdDone), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] dec_model(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 5'b0_0010;
        if (op == 2'b01) return 5'b0_0110;
        case (f)
            6'd32, 6'd33: return 5'b0_0010;
            6'd34, 6'd35: return 5'b0_0110;
            6'd36: return 5'b0_0000;
            6'd37: return 5'b0_0001;
            6'd38: return 5'b0_0011;
            6'd39: return 5'b0_0100;
            6'd42: return 5'b0_0111;
            6'd43: return 5'b0_1000;
            6'd0:  return 5'b0_1001;
            6'd2:  return 5'b0_1010;
            6'd3:  return 5'b0_1011;
            6'd16: return 5'b0_1100;
            6'd18: return 5'b0_1101;
            6'd24, 6'd25, 6'd26, 6'd27: return 5'b0_1111;
            default: return 5'b1_1111;
        endcase
    endfunction

    function automatic void md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
        longint    sa, sb, sp;
        logic [63:0] up;
        int        q, r;
        h = '0; l = '0;
        case (f)
            6'd24: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                sp = sa * sb;
                h = sp[63:32]; l = sp[31:0];
            end
            6'd25: begin
                up = {32'b0, a} * {32'b0, b};
                h = up[63:32]; l = up[31:0];
            end
            6'd26: begin
                if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = 32'd0; end
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    l = q; h = r;
                end
            end
            default: begin
                if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    int           rem_cyc = 0;
    logic [31:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            rem_cyc = 0; m_hi = '0; m_lo = '0; chk_en = 1'b1;
        end else if (rem_cyc != 0) begin
            if (rem_cyc == 1) begin m_hi = p_hi; m_lo = p_lo; end
            rem_cyc--;
        end else if (issue && aluOp[1] && funct >= 6'd24 && funct <= 6'd27) begin
            md_model(funct, opA, opB, p_hi, p_lo);
            rem_cyc = W + 1;
        end
    end

    always @(negedge clk) begin
        logic [4:0] d;
        logic       eb, ed, es;
        if (chk_en) begin
            d  = dec_model(aluOp, funct);
            eb = (rem_cyc != 0);
            ed = (rem_cyc == 1);
            es = eb && issue && aluOp[1] &&
                 ((funct >= 6'd24 && funct <= 6'd27) || funct == 6'd16 || funct == 6'd18);
            chk("aluControl", 32'(aluControl), 32'(d[3:0]));
            chk("illegal", 32'(illegal), 32'(d[4]));
            chk("mdBusy", 32'(mdBusy), 32'(eb));
            chk("mdDone", 32'(mdDone), 32'(ed));
            chk("stall", 32'(stall), 32'(es));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int busy, done;
        busy = 0; done = 0;
        @(posedge clk); #1;
        aluOp = 2'b10; funct = f; opA = a; opB = b; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0; aluOp = 2'b00; funct = 6'd0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!mdBusy) break;
            busy++;
            if (mdDone) done++;
        end
        chk({name, " busy_cycles"}, 32'(busy), 32'd33);
        chk({name, " done_pulses"}, 32'(done), 32'd1);
        chk({name, " hi_lit"}, hi, eh);
        chk({name, " lo_lit"}, lo, el);
    endtask

    typedef struct { logic [1:0] op; logic [5:0] f; logic [3:0] code; logic ill; } dec_vec_t;
    dec_vec_t dv[9];

    initial begin
        int  n_done, stall_at_done, dropped;
        bit  prev_done;

        dv[0] = '{2'b00, 6'd0,  4'b0010, 1'b0};
        dv[1] = '{2'b01, 6'd0,  4'b0110, 1'b0};
        dv[2] = '{2'b10, 6'd36, 4'b0000, 1'b0};
        dv[3] = '{2'b10, 6'd43, 4'b1000, 1'b0};
        dv[4] = '{2'b10, 6'd3,  4'b1011, 1'b0};
        dv[5] = '{2'b10, 6'd50, 4'b1111, 1'b1};
        dv[6] = '{2'b11, 6'd42, 4'b0111, 1'b0};
        dv[7] = '{2'b10, 6'd18, 4'b1101, 1'b0};
        dv[8] = '{2'b10, 6'd25, 4'b1111, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset mdBusy", 32'(mdBusy), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst_n = 1'b1;

        foreach (dv[i]) begin
            @(posedge clk); #1;
            aluOp = dv[i].op; funct = dv[i].f;
            @(negedge clk);
            chk($sformatf("dec%0d code", i), 32'(aluControl), 32'(dv[i].code));
            chk($sformatf("dec%0d illegal", i), 32'(illegal), 32'(dv[i].ill));
        end

        run_op("mult", 6'd24, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("divu", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div", 6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 6'd27, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("divovf", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // mflo two cycles after a mult
        @(posedge clk); #1;
        aluOp = 2'b10; funct = 6'd24; opA = 32'd5; opB = 32'd9; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0;
        @(posedge clk); #1;
        funct = 6'd18; issue = 1'b1;
        prev_done = 1'b0; stall_at_done = 0; dropped = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mdDone) stall_at_done = int'(stall);
            if (!stall) begin dropped = 1; break; end
            prev_done = mdDone;
        end
        chk("mflo stall_at_done", 32'(stall_at_done), 32'd1);
        chk("mflo released_after_done", 32'(prev_done), 32'd1);
        chk("mflo released", 32'(dropped), 32'd1);
        chk("mflo lo", lo, 32'd45);
        @(posedge clk); #1;
        issue = 1'b0; aluOp = 2'b00; funct = 6'd0;

        // reset mid-multu
        @(posedge clk); #1;
        aluOp = 2'b10; funct = 6'd25; opA = 32'd1000; opB = 32'd1000; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0; aluOp = 2'b00; funct = 6'd0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre-reset busy", 32'(mdBusy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort mdBusy", 32'(mdBusy), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdDone) n_done++;
        end
        chk("abort no_done", 32'(n_done), 32'd0);

        run_op("multu", 6'd25, 32'd6, 32'd7, 32'd0, 32'd42);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
